// File: rtl/up_pkg.sv
// Shared definitions for the parametrised accumulator core: opcodes, FSM states, ALU ops.
package up_pkg;

    localparam logic [3:0] OP_JC    = 4'd0;
    localparam logic [3:0] OP_JNC   = 4'd1;
    localparam logic [3:0] OP_CMPI  = 4'd2;
    localparam logic [3:0] OP_CMPM  = 4'd3;
    localparam logic [3:0] OP_LIT   = 4'd4;
    localparam logic [3:0] OP_IN    = 4'd5;
    localparam logic [3:0] OP_LD    = 4'd6;
    localparam logic [3:0] OP_ST    = 4'd7;
    localparam logic [3:0] OP_JZ    = 4'd8;
    localparam logic [3:0] OP_JNZ   = 4'd9;
    localparam logic [3:0] OP_ADDI  = 4'd10;
    localparam logic [3:0] OP_ADDM  = 4'd11;
    localparam logic [3:0] OP_JMP   = 4'd12;
    localparam logic [3:0] OP_OUT   = 4'd13;
    localparam logic [3:0] OP_NANDI = 4'd14;
    localparam logic [3:0] OP_NANDM = 4'd15;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StExec  = 2'd1,
        StWait  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        AluAdd  = 2'd0,
        AluSub  = 2'd1,
        AluNand = 2'd2,
        AluPass = 2'd3
    } alu_op_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST) || (op == OP_CMPM) ||
               (op == OP_ADDM) || (op == OP_NANDM);
    endfunction

endpackage

// File: rtl/up_alu.sv
// Combinational ALU: add with carry-out, subtract with no-borrow carry, NAND, pass-through of b.
module up_alu
    import up_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  alu_op_e           i_op,
    output logic [DATA_W-1:0] o_y,
    output logic              o_c,
    output logic              o_z
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_y = i_b;
        o_c = 1'b0;
        case (i_op)
            AluAdd: begin
                o_y = w_sum[DATA_W-1:0];
                o_c = w_sum[DATA_W];
            end
            AluSub: begin
                o_y = w_diff[DATA_W-1:0];
                // Carry set means no borrow, i.e. a >= b unsigned.
                o_c = ~w_diff[DATA_W];
            end
            AluNand: o_y = ~(i_a & i_b);
            default: o_y = i_b;
        endcase
    end

    assign o_z = (o_y == '0);

endmodule

// File: rtl/up_core_param.sv
// Parametrised 16-opcode accumulator core with external program ROM and data RAM.
// Define UP_RAM_WAIT_EN to let memory opcodes stall in a WAIT state until ram_ready.
module up_core_param
    import up_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned N_CH   = 2,
    parameter int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [ADDR_W-1:0]        prog_addr,
    input  logic [ADDR_W+3:0]        prog_data,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata,
    output logic                     ram_we,
    output logic                     ram_re,
    input  logic                     ram_ready,
    input  logic [N_CH*DATA_W-1:0]   in_ports,
    output logic [N_CH*DATA_W-1:0]   out_ports,
    output logic [DATA_W-1:0]        acc,
    output logic                     c_flag,
    output logic                     z_flag,
    output logic [ADDR_W-1:0]        pc,
    output logic                     phase,
    output logic [3:0]               instr
);

    state_e                  r_state, w_state_d;
    logic [ADDR_W+3:0]       r_ir;
    logic [ADDR_W-1:0]       r_pc;
    logic [DATA_W-1:0]       r_acc;
    logic                    r_c, r_z;
    logic [N_CH*DATA_W-1:0]  r_out;

    logic [3:0]              w_op;
    logic [ADDR_W-1:0]       w_f;
    logic [DATA_W-1:0]       w_imm;
    logic [CH_W-1:0]         w_ch;
    logic [DATA_W-1:0]       w_in_sel;
    logic                    w_active, w_complete, w_done, w_taken;
    alu_op_e                 w_alu_op;
    logic [DATA_W-1:0]       w_alu_b, w_alu_y;
    logic                    w_alu_c, w_alu_z;

    assign w_op     = r_ir[ADDR_W+3:ADDR_W];
    assign w_f      = r_ir[ADDR_W-1:0];
    assign w_imm    = w_f[DATA_W-1:0];
    assign w_ch     = w_f[DATA_W +: CH_W];
    assign w_active = (r_state != StFetch);
    assign w_done   = w_active && w_complete;

`ifdef UP_RAM_WAIT_EN
    assign w_complete = !is_mem_op(w_op) || ram_ready;
`else
    logic w_unused_ready;
    assign w_unused_ready = ram_ready;
    assign w_complete     = 1'b1;
`endif

    // Channels beyond N_CH read as zero.
    always_comb begin
        w_in_sel = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (w_ch == CH_W'(k)) w_in_sel = in_ports[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_alu_op = AluPass;
        w_alu_b  = w_imm;
        case (w_op)
            OP_ADDI:  w_alu_op = AluAdd;
            OP_CMPI:  w_alu_op = AluSub;
            OP_NANDI: w_alu_op = AluNand;
            OP_ADDM:  begin w_alu_op = AluAdd;  w_alu_b = ram_rdata; end
            OP_CMPM:  begin w_alu_op = AluSub;  w_alu_b = ram_rdata; end
            OP_NANDM: begin w_alu_op = AluNand; w_alu_b = ram_rdata; end
            OP_LD:    w_alu_b = ram_rdata;
            OP_IN:    w_alu_b = w_in_sel;
            default:  ;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            OP_JMP:  w_taken = 1'b1;
            OP_JC:   w_taken = r_c;
            OP_JNC:  w_taken = !r_c;
            OP_JZ:   w_taken = r_z;
            OP_JNZ:  w_taken = !r_z;
            default: w_taken = 1'b0;
        endcase
    end

    up_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a  (r_acc),
        .i_b  (w_alu_b),
        .i_op (w_alu_op),
        .o_y  (w_alu_y),
        .o_c  (w_alu_c),
        .o_z  (w_alu_z)
    );

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StFetch:        w_state_d = StExec;
            StExec, StWait: w_state_d = w_complete ? StFetch : StWait;
            default:        w_state_d = StFetch;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= StFetch;
        else        r_state <= w_state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ir  <= '0;
            r_pc  <= '0;
            r_acc <= '0;
            r_c   <= 1'b0;
            r_z   <= 1'b0;
            r_out <= '0;
        end else begin
            if (r_state == StFetch) r_ir <= prog_data;
            if (w_done) begin
                r_pc <= w_taken ? w_f : r_pc + ADDR_W'(1);
                case (w_op)
                    OP_LIT, OP_IN, OP_LD: r_acc <= w_alu_y;
                    OP_ADDI, OP_ADDM: begin
                        r_acc <= w_alu_y;
                        r_c   <= w_alu_c;
                        r_z   <= w_alu_z;
                    end
                    OP_CMPI, OP_CMPM: begin
                        r_c <= w_alu_c;
                        r_z <= w_alu_z;
                    end
                    OP_NANDI, OP_NANDM: begin
                        r_acc <= w_alu_y;
                        r_z   <= w_alu_z;
                    end
                    OP_OUT: begin
                        for (int unsigned k = 0; k < N_CH; k++) begin
                            if (w_ch == CH_W'(k)) r_out[k*DATA_W +: DATA_W] <= r_acc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign prog_addr = r_pc;
    assign ram_addr  = w_active ? w_f : '0;
    assign ram_wdata = r_acc;
    assign ram_we    = w_active && (w_op == OP_ST);
    assign ram_re    = w_active && is_mem_op(w_op) && (w_op != OP_ST);
    assign out_ports = r_out;
    assign acc       = r_acc;
    assign c_flag    = r_c;
    assign z_flag    = r_z;
    assign pc        = r_pc;
    assign phase     = w_active;
    assign instr     = w_op;

endmodule

// File: tb/tb_up_core_param.sv
// Directed self-checking bench for up_core_param (default 4-bit data, 12-bit address, 2 channels).
module tb_up_core_param;
    import up_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] prog_addr;
    logic [15:0] prog_data;
    logic [11:0] ram_addr;
    logic [3:0]  ram_wdata, ram_rdata;
    logic        ram_we, ram_re;
    logic        ram_ready = 1'b1;
    logic [7:0]  in_ports = 8'h00;
    logic [7:0]  out_ports;
    logic [3:0]  acc;
    logic        c_flag, z_flag;
    logic [11:0] pc;
    logic        phase;
    logic [3:0]  instr;

    logic [15:0] rom [0:4095];
    logic [3:0]  ram [0:4095];
    int          we_count = 0;
    int          both_count = 0;
    int          errors = 0;
    int          checks = 0;
    int          base;

    always #5 clock = ~clock;

    assign prog_data = rom[prog_addr];
    assign ram_rdata = ram[ram_addr];

    always @(posedge clock) begin
        if (ram_we && ram_ready) begin
            ram[ram_addr] <= ram_wdata;
            we_count++;
        end
        if (ram_we && ram_re) both_count++;
    end

    up_core_param u_dut (
        .clock     (clock),
        .reset     (reset),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_ready (ram_ready),
        .in_ports  (in_ports),
        .out_ports (out_ports),
        .acc       (acc),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .pc        (pc),
        .phase     (phase),
        .instr     (instr)
    );

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] f);
        return {op, f};
    endfunction

    task automatic clear_rom();
        for (int a = 0; a < 4096; a++) rom[a] = {OP_JMP, 12'(a)};
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = ins(OP_LIT, 12'h005);
        rom[1] = ins(OP_ST, 12'h123);
        ram_ready = 1'b1;
        do_reset();
        base = we_count;
        step(3);
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL reset_pre_we: got %0h want 1", ram_we); end
        #2 reset = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_async_we: got %0h want 0", ram_we); end
        checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL reset_async_re: got %0h want 0", ram_re); end
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h want 000", pc); end
        checks++; if (acc !== 4'h0) begin errors++; $display("FAIL reset_acc: got %h want 0", acc); end
        checks++; if ({c_flag, z_flag} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {c_flag, z_flag}); end
        checks++; if (out_ports !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", out_ports); end
        @(negedge clock);
        checks++; if (we_count !== base) begin errors++; $display("FAIL reset_no_write: got %0d want %0d", we_count, base); end
        reset = 1'b1;
        checks++; if ({phase, prog_addr} !== 13'h0000) begin errors++; $display("FAIL reset_first_fetch: got %h want 0000", {phase, prog_addr}); end
        step(1);
        checks++; if ({phase, instr} !== 5'h14) begin errors++; $display("FAIL reset_first_exec: got %h want 14", {phase, instr}); end
    endtask

    task automatic test_arith();
        clear_rom();
        rom[0] = ins(OP_LIT, 12'h007);
        rom[1] = ins(OP_ADDI, 12'h00A);
        rom[2] = ins(OP_NANDI, 12'h00F);
        do_reset();
        step(4);
        checks++; if ({acc, c_flag, z_flag} !== 6'b0001_10) begin errors++; $display("FAIL addi: got %b want 000110", {acc, c_flag, z_flag}); end
        step(2);
        checks++; if ({acc, c_flag, z_flag} !== 6'b1110_10) begin errors++; $display("FAIL nandi: got %b want 111010", {acc, c_flag, z_flag}); end
    endtask

    task automatic test_ld_st();
        clear_rom();
        rom[0] = ins(OP_LIT, 12'h005);
        rom[1] = ins(OP_ST, 12'h123);
        rom[2] = ins(OP_LIT, 12'h000);
        rom[3] = ins(OP_LD, 12'h123);
        ram_ready = 1'b1;
        do_reset();
        base = we_count;
        step(3);
        checks++; if ({ram_we, ram_re, ram_addr, ram_wdata} !== 18'b10_0001_0010_0011_0101) begin
            errors++; $display("FAIL st_bus: got we=%0b re=%0b addr=%h wdata=%h want we=1 re=0 addr=123 wdata=5", ram_we, ram_re, ram_addr, ram_wdata);
        end
        step(1);
        checks++; if ({ram_we, ram_addr} !== 13'h0000) begin errors++; $display("FAIL st_release: got we=%0b addr=%h want we=0 addr=000", ram_we, ram_addr); end
        checks++; if (we_count - base !== 1) begin errors++; $display("FAIL st_once: got %0d want 1", we_count - base); end
        step(3);
        checks++; if ({ram_re, ram_we, ram_addr} !== 14'h2123) begin errors++; $display("FAIL ld_bus: got re=%0b we=%0b addr=%h want re=1 we=0 addr=123", ram_re, ram_we, ram_addr); end
        step(1);
        checks++; if (acc !== 4'h5) begin errors++; $display("FAIL ld_acc: got %h want 5", acc); end
        checks++; if (both_count !== 0) begin errors++; $display("FAIL we_re_exclusive: got %0d want 0", both_count); end
    endtask

    task automatic test_cmp_jump();
        clear_rom();
        rom[12'h000] = ins(OP_LIT, 12'h003);
        rom[12'h001] = ins(OP_CMPI, 12'h003);
        rom[12'h002] = ins(OP_JZ, 12'h040);
        rom[12'h040] = ins(OP_CMPI, 12'h004);
        rom[12'h041] = ins(OP_JNC, 12'h080);
        rom[12'h080] = ins(OP_JC, 12'h200);
        do_reset();
        step(6);
        checks++; if ({acc, c_flag, z_flag} !== 6'b0011_11) begin errors++; $display("FAIL cmp_eq: got %b want 001111", {acc, c_flag, z_flag}); end
        checks++; if (pc !== 12'h040) begin errors++; $display("FAIL jz_taken: got %h want 040", pc); end
        step(4);
        checks++; if ({acc, c_flag, z_flag} !== 6'b0011_00) begin errors++; $display("FAIL cmp_lt: got %b want 001100", {acc, c_flag, z_flag}); end
        checks++; if (pc !== 12'h080) begin errors++; $display("FAIL jnc_taken: got %h want 080", pc); end
        step(2);
        checks++; if (pc !== 12'h081) begin errors++; $display("FAIL jc_not_taken: got %h want 081", pc); end
    endtask

    task automatic test_io_wrap();
        clear_rom();
        in_ports = 8'h93;
        rom[12'h000] = ins(OP_LIT, 12'h006);
        rom[12'h001] = ins(OP_OUT, 12'h010);
        rom[12'h002] = ins(OP_JMP, 12'hFFD);
        rom[12'hFFD] = ins(OP_IN, 12'h010);
        rom[12'hFFE] = ins(OP_OUT, 12'h000);
        rom[12'hFFF] = ins(OP_NANDI, 12'h00F);
        do_reset();
        step(6);
        checks++; if ({pc, out_ports} !== 20'hFFD60) begin errors++; $display("FAIL out_ch1: got pc=%h out=%h want pc=ffd out=60", pc, out_ports); end
        step(2);
        checks++; if (acc !== 4'h9) begin errors++; $display("FAIL in_ch1: got %h want 9", acc); end
        step(2);
        checks++; if (out_ports !== 8'h69) begin errors++; $display("FAIL out_ch0: got %h want 69", out_ports); end
        step(2);
        checks++; if ({pc, acc} !== 16'h0006) begin errors++; $display("FAIL pc_wrap: got pc=%h acc=%h want pc=000 acc=6", pc, acc); end
    endtask

`ifdef UP_RAM_WAIT_EN
    task automatic test_ram_wait();
        clear_rom();
        rom[0] = ins(OP_LIT, 12'h00D);
        rom[1] = ins(OP_ST, 12'h200);
        rom[2] = ins(OP_LIT, 12'h000);
        rom[3] = ins(OP_LD, 12'h200);
        ram_ready = 1'b1;
        do_reset();
        step(6);
        ram_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++; if ({phase, ram_re, ram_we, ram_addr, acc} !== 19'b110_0010_0000_0000_0000) begin
                errors++; $display("FAIL wait_hold%0d: got ph=%0b re=%0b we=%0b addr=%h acc=%h want 1 1 0 200 0", i, phase, ram_re, ram_we, ram_addr, acc);
            end
        end
        ram_ready = 1'b1;
        step(1);
        checks++; if ({phase, pc, acc} !== 17'b0_0000_0000_0100_1101) begin errors++; $display("FAIL wait_done: got ph=%0b pc=%h acc=%h want 0 004 d", phase, pc, acc); end
    endtask
`else
    task automatic test_ram_wait();
        clear_rom();
        rom[0] = ins(OP_LIT, 12'h00B);
        rom[1] = ins(OP_ST, 12'h055);
        rom[2] = ins(OP_LIT, 12'h000);
        rom[3] = ins(OP_LD, 12'h055);
        ram_ready = 1'b1;
        do_reset();
        step(4);
        ram_ready = 1'b0;
        step(3);
        checks++; if ({phase, ram_re} !== 2'b11) begin errors++; $display("FAIL ld_noready_exec: got %b want 11", {phase, ram_re}); end
        step(1);
        checks++; if ({phase, pc, acc} !== 17'b0_0000_0000_0100_1011) begin errors++; $display("FAIL ld_noready_done: got ph=%0b pc=%h acc=%h want 0 004 b", phase, pc, acc); end
        ram_ready = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_ld_st();
        test_cmp_jump();
        test_io_wrap();
        test_ram_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up_core_param.md
Name: up_core_param

Overview:
- Parametrised successor to the team's 4-bit accumulator processor.
- Same 16-opcode accumulator ISA: JC, JNC, CMPI, CMPM, LIT, IN, LD, ST, JZ, JNZ, ADDI, ADDM, JMP, OUT, NANDI, NANDM.
- Generalised in data width, address width and number of I/O channels.
- Program ROM and data RAM are external; the core owns PC, instruction register, accumulator, flags, decode and output registers.

Parameters:
- DATA_W, 4, accumulator/RAM/IO data width (>=2).
- ADDR_W, 12, program/RAM address width (>= DATA_W + CH_W).
- N_CH, 2, number of input and output channels (>=1).
- CH_W, 1, channel-select width, = max(1, clog2(N_CH)).

Ports:
- clock, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-low; clears all state.
- prog_addr, out, ADDR_W, program ROM address (= pc).
- prog_data, in, 4+ADDR_W, opcode in [ADDR_W+3:ADDR_W], field F in [ADDR_W-1:0]; combinational ROM.
- ram_addr, out, ADDR_W, data RAM address.
- ram_wdata, out, DATA_W, write data.
- ram_rdata, in, DATA_W, read data.
- ram_we, out, 1, write strobe.
- ram_re, out, 1, read strobe.
- ram_ready, in, 1, RAM handshake; used only with UP_RAM_WAIT_EN.
- in_ports, in, N_CH*DATA_W, channel k at [k*DATA_W +: DATA_W].
- out_ports, out, N_CH*DATA_W, registered output channels.
- acc, out, DATA_W, accumulator.
- c_flag, out, 1, carry flag.
- z_flag, out, 1, zero flag.
- pc, out, ADDR_W, program counter.
- phase, out, 1, 0 = FETCH, 1 = EXEC/WAIT.
- instr, out, 4, latched opcode.

Behaviour:
- Reset (async, reset=0): pc=0, ir=0, acc=0, c_flag=0, z_flag=0, out_ports=0, state=FETCH. ram_we and ram_re drop to 0 immediately, including mid-instruction.
- Immediate: IMM = F[DATA_W-1:0]. Channel: CH = F[DATA_W +: CH_W]; a CH >= N_CH reads 0 or writes nothing.
- States:
  - FETCH: ir <= prog_data; -> EXEC.
  - EXEC: execute the opcode. Then pc <= pc+1 (mod 2^ADDR_W) or, for a taken jump, pc <= F. -> FETCH.
  - WAIT: exists only with the feature.
- Timing: every instruction takes exactly 2 cycles without the feature.
- LIT: acc <= IMM; flags held.
- IN: acc <= in_ports[CH]; flags held.
- OUT: out_ports[CH] <= acc; other channels held.
- LD: ram_re=1, ram_addr=F in EXEC; acc <= ram_rdata; flags held.
- ST: ram_we=1 for exactly one EXEC cycle; ram_addr=F, ram_wdata=acc.
- ADDI/ADDM: {C,acc} <= acc + operand, computed DATA_W+1 wide; Z <= (new acc == 0).
- CMPI/CMPM: r = acc - operand. C <= 1 iff acc >= operand (unsigned, no borrow); Z <= (r == 0); acc held.
- NANDI/NANDM: acc <= ~(acc & operand); Z updated; C held.
- Jumps:
  - JMP: always taken.
  - JC / JNC: taken iff C=1 / C=0.
  - JZ / JNZ: taken iff Z=1 / Z=0.
  - Flags and acc held.
- ram_addr is driven with F during EXEC/WAIT and with 0 otherwise. ram_we and ram_re are never both 1.
- pc wraps from 2^ADDR_W-1 to 0 with no flag effect.

Optional Feature:
- Macro: UP_RAM_WAIT_EN.
- Defined: memory opcodes (LD, ST, CMPM, ADDM, NANDM) enter WAIT when ram_ready=0 during EXEC.
  - WAIT holds ram_addr, ram_we/ram_re and ram_wdata stable.
  - The instruction completes in the first cycle with ram_ready=1; the total is 2 + n_wait cycles.
  - A ST write occurs only in that completing cycle.
- Undefined: ram_ready is ignored and RAM is single-cycle.

Decomposition:
- Shared package up_pkg:
  - 4-bit opcode localparams (OP_JC=0 … OP_NANDM=15).
  - State encoding FETCH/EXEC/WAIT.
  - ALU op codes ADD/SUB/NAND/PASS.
- One sub-module up_alu (combinational, DATA_W): inputs a, b, op; outputs y, c, z.

Test Plan:
- Reset: assert reset mid-ST (ram_we=1) -> ram_we=0 the same cycle. After release: pc=0, acc=0, flags=0, out_ports=0; first fetch at prog_addr=0.
- LIT 0x7; ADDI 0xA -> acc=0x1, C=1, Z=0 after 4 cycles. Then NANDI 0xF -> acc=0xE, C still 1.
- LIT 0x5; ST 0x123; LIT 0; LD 0x123 -> one-cycle ram_we with ram_addr=0x123, ram_wdata=0x5; final acc=0x5.
- LIT 0x3; CMPI 0x3; JZ 0x040 -> Z=1, C=1, acc=0x3, pc=0x040. Then CMPI 0x4; JNC 0x080 -> C=0, pc=0x080.
- in_ports ch1=0x9: IN ch1; OUT ch0 -> out_ports[3:0]=0x9, ch1 output unchanged. Place the final instruction at pc=0xFFF -> pc wraps to 0x000.
- UP_RAM_WAIT_EN: LD with ram_ready low for 3 cycles -> 5-cycle instruction; ram_re and ram_addr stable throughout; acc loads on the ready cycle.
